uart_rx: RTL and testbench

//  8N1 UART receiver: the receive-side counterpart of the uart_tx transmitter on the same line.

---
 rtl/uart_rx_pkg.sv | 11 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: default bit period and receiver FSM encoding.
package uart_rx_pkg;
   localparam int BAUD_DIV_DEF = 5208;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input; reset value selectable per use.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, valid/ready output register,
// framing-error and overrun pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LIM = CW'(HALF_DIV - 1);
   localparam logic [CW-1:0] FULL_LIM = CW'(BAUD_DIV - 1);

   rx_state_e     state;
   logic          rx_s;
   logic          rx_d;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          fall;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   assign fall = rx_d & ~rx_s;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rx_d      <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_d      <= rx_s;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // a load in STOP below overrides this clear on the same edge
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (fall)
                  state <= START;
            end
            START: begin
               if (baud_cnt == HALF_LIM) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == FULL_LIM) begin
                  baud_cnt           <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               // leave at mid-stop-bit so a back-to-back start edge is not missed
               if (baud_cnt == FULL_LIM) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                  end else if (rx_valid && !rx_ready) begin
                     overrun <= 1'b1;
                  end else begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16: an inline serial model drives rx_in.
module tb_uart_rx;
   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int vld_cycles = 0;
   logic [7:0] xq[$];

   uart_rx #(.BAUD_DIV(BD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // consumer-side monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && rx_ready) begin
            xfer_cnt = xfer_cnt + 1;
            xq.push_back(rx_data);
         end
         if (rx_valid)  vld_cycles = vld_cycles + 1;
         if (frame_err) fe_cnt = fe_cnt + 1;
         if (overrun)   ov_cnt = ov_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      tick(BD);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   initial begin
      int x0, f0, o0, v0, q0;

      tick(3);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {frame_err, overrun}, 0);
      rst_n = 1'b1;
      tick(5);

      // 1: single byte, consumer always ready
      rx_ready = 1'b1;
      x0 = xfer_cnt; v0 = vld_cycles; q0 = xq.size();
      send_frame(8'h61, 1'b1);
      tick(6);
      check("t1_xfer", xfer_cnt - x0, 1);
      check("t1_vcyc", vld_cycles - v0, 1);
      if (xq.size() > q0) check("t1_data", xq[q0], 8'h61);
      check("t1_flags", fe_cnt + ov_cnt, 0);

      // 2: short glitch rejected
      x0 = xfer_cnt; f0 = fe_cnt; o0 = ov_cnt;
      rx_in = 1'b0;
      tick(5);
      rx_in = 1'b1;
      check("t2_busy_hi", busy, 1);
      tick(20);
      check("t2_busy_lo", busy, 0);
      check("t2_none", (xfer_cnt - x0) + (fe_cnt - f0) + (ov_cnt - o0), 0);

      // 3: bad stop bit
      x0 = xfer_cnt; f0 = fe_cnt; v0 = vld_cycles;
      send_frame(8'hA5, 1'b0);
      rx_in = 1'b1;
      tick(20);
      check("t3_fe", fe_cnt - f0, 1);
      check("t3_vcyc", vld_cycles - v0, 0);
      check("t3_valid", rx_valid, 0);

      // 4: back-to-back with consumer stalled
      rx_ready = 1'b0;
      x0 = xfer_cnt; o0 = ov_cnt; q0 = xq.size();
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      tick(6);
      check("t4_valid", rx_valid, 1);
      check("t4_data", rx_data, 8'h12);
      check("t4_ov", ov_cnt - o0, 1);
      rx_ready = 1'b1;
      tick(2);
      check("t4_valid_lo", rx_valid, 0);
      check("t4_xfer", xfer_cnt - x0, 1);
      if (xq.size() > q0) check("t4_xdata", xq[q0], 8'h12);

      // 5: reset during data bit 4 of 8'hFF, then 8'h3C
      x0 = xfer_cnt; q0 = xq.size(); f0 = fe_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx_in = 1'b1;
      tick(BD / 2);
      rst_n = 1'b0;
      tick(3);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_valid", rx_valid, 0);
      rst_n = 1'b1;
      tick(20);
      send_frame(8'h3C, 1'b1);
      tick(6);
      check("t5_xfer", xfer_cnt - x0, 1);
      if (xq.size() > q0) check("t5_data", xq[q0], 8'h3C);
      check("t5_fe", fe_cnt - f0, 0);

      // 6: back-to-back 00 / FF, consumer ready
      x0 = xfer_cnt; q0 = xq.size(); f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick(6);
      check("t6_xfer", xfer_cnt - x0, 2);
      if (xq.size() >= q0 + 2) begin
         check("t6_d0", xq[q0], 8'h00);
         check("t6_d1", xq[q0+1], 8'hFF);
      end
      check("t6_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

      // 7: break condition gives exactly one framing error
      x0 = xfer_cnt; f0 = fe_cnt;
      rx_in = 1'b0;
      tick(400);
      check("t7_idle", busy, 0);
      rx_in = 1'b1;
      tick(40);
      check("t7_fe", fe_cnt - f0, 1);
      check("t7_xfer", xfer_cnt - x0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
